// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// Entry fields are sized for the widest supported configuration and zero-extended.
package fwd_scoreboard_pkg;

  localparam int REG_BITS      = 5;
  localparam int DEPTH_DEFAULT = 3;
  localparam int SEL_W         = $clog2(DEPTH_DEFAULT + 1);
  localparam int FWD_RF        = 0;

  localparam int ENTRY_RD_W  = 8;
  localparam int ENTRY_CNT_W = 8;

  typedef struct packed {
    logic                   v;
    logic [ENTRY_RD_W-1:0]  rd;
    logic [ENTRY_CNT_W-1:0] cnt;
  } entry_t;

endpackage

// File: rtl/fwd_port_match.sv
// Priority match of one read port against the shadow pipeline.
// Index 0 is stage 1 (youngest); the first live match decides sel or pending.
module fwd_port_match #(
  parameter int DEPTH    = 3,
  parameter int ADDR_W   = 5,
  parameter int SEL_BITS = 2
) (
  input  fwd_scoreboard_pkg::entry_t stages [DEPTH],
  input  logic [ADDR_W-1:0]          addr,
  output logic [SEL_BITS-1:0]        sel,
  output logic                       pending
);
  import fwd_scoreboard_pkg::*;

  logic found;

  always_comb begin
    sel     = SEL_BITS'(FWD_RF);
    pending = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && stages[k].v && (addr != '0) &&
          (stages[k].rd == ENTRY_RD_W'(addr))) begin
        found = 1'b1;
        if (stages[k].cnt == '0) begin
          sel = SEL_BITS'(k + 1);
        end else begin
          pending = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shadow pipeline of in-flight writes with per-entry
// ready countdown, per-port bypass select, load-use stall and stall counter.
module fwd_scoreboard #(
  parameter int REG_BITS = fwd_scoreboard_pkg::REG_BITS,
  parameter int NUM_RD   = 4,
  parameter int DEPTH    = 3,
  parameter int LAT_BITS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  input  logic                                 issue_wr_en,
  input  logic [REG_BITS-1:0]                  issue_rd,
  input  logic [LAT_BITS-1:0]                  issue_lat,
  input  logic [NUM_RD*REG_BITS-1:0]           rd_addr,
  input  logic [NUM_RD-1:0]                    rd_used,
  input  logic [DEPTH-1:0]                     flush_mask,
  output logic [NUM_RD*$clog2(DEPTH+1)-1:0]    fwd_sel,
  output logic                                 stall,
  output logic [15:0]                          hazard_count
);
  import fwd_scoreboard_pkg::*;

  localparam int SEL_W = $clog2(DEPTH + 1);

  entry_t                 stage_q [DEPTH];
  entry_t                 stage_d [DEPTH];
  logic [15:0]            hazard_count_q, hazard_count_d;
  logic [NUM_RD-1:0]      pending;
  logic [ENTRY_CNT_W-1:0] lat_clamped;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_port_match #(
      .DEPTH   (DEPTH),
      .ADDR_W  (REG_BITS),
      .SEL_BITS(SEL_W)
    ) u_match (
      .stages (stage_q),
      .addr   (rd_addr[i*REG_BITS +: REG_BITS]),
      .sel    (fwd_sel[i*SEL_W +: SEL_W]),
      .pending(pending[i])
    );
  end

  assign stall        = |(pending & rd_used);
  assign hazard_count = hazard_count_q;

  // Clamping to DEPTH-1 means every entry is forwardable before it retires.
  always_comb begin
    lat_clamped = ENTRY_CNT_W'(issue_lat);
    if (lat_clamped > ENTRY_CNT_W'(DEPTH - 1)) begin
      lat_clamped = ENTRY_CNT_W'(DEPTH - 1);
    end

    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end

    for (int k = DEPTH - 1; k >= 1; k--) begin
      stage_d[k].v   = stage_q[k-1].v & ~flush_mask[k-1];
      stage_d[k].rd  = stage_q[k-1].rd;
      stage_d[k].cnt = (stage_q[k-1].cnt != '0) ?
                       stage_q[k-1].cnt - ENTRY_CNT_W'(1) : '0;
    end

    stage_d[0].v   = issue_valid & issue_wr_en & ~stall &
                     (issue_rd != '0) & ~flush_mask[0];
    stage_d[0].rd  = ENTRY_RD_W'(issue_rd);
    stage_d[0].cnt = lat_clamped;

    hazard_count_d = hazard_count_q;
    if (stall && (hazard_count_q != 16'hFFFF)) begin
      hazard_count_d = hazard_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      hazard_count_q <= '0;
    end else begin
      stage_q        <= stage_d;
      hazard_count_q <= hazard_count_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, randomized run against a
// timestamp-based model, and counter saturation on a deep configuration.
module tb_fwd_scoreboard;

  localparam int RB = 5;
  localparam int NR = 4;
  localparam int DP = 3;
  localparam int SW = 2;
  localparam int DDP = 32;
  localparam int DSW = 6;
  localparam int DLB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              issue_valid = 1'b0, issue_wr_en = 1'b0;
  logic [RB-1:0]     issue_rd = '0;
  logic [1:0]        issue_lat = '0;
  logic [NR*RB-1:0]  rd_addr = '0;
  logic [NR-1:0]     rd_used = '0;
  logic [DP-1:0]     flush_mask = '0;
  logic [NR*SW-1:0]  fwd_sel;
  logic              stall;
  logic [15:0]       hazard_count;

  logic              d_rst = 1'b1;
  logic              d_issue_valid = 1'b0, d_issue_wr_en = 1'b0;
  logic [RB-1:0]     d_issue_rd = '0;
  logic [DLB-1:0]    d_issue_lat = '0;
  logic [NR*RB-1:0]  d_rd_addr = '0;
  logic [NR-1:0]     d_rd_used = '0;
  logic [DDP-1:0]    d_flush_mask = '0;
  logic [NR*DSW-1:0] d_fwd_sel;
  logic              d_stall;
  logic [15:0]       d_hazard_count;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .rd_addr(rd_addr), .rd_used(rd_used),
    .flush_mask(flush_mask), .fwd_sel(fwd_sel), .stall(stall), .hazard_count(hazard_count)
  );

  fwd_scoreboard #(.DEPTH(DDP), .LAT_BITS(DLB)) dut_deep (
    .clk(clk), .rst(d_rst), .issue_valid(d_issue_valid), .issue_wr_en(d_issue_wr_en),
    .issue_rd(d_issue_rd), .issue_lat(d_issue_lat), .rd_addr(d_rd_addr), .rd_used(d_rd_used),
    .flush_mask(d_flush_mask), .fwd_sel(d_fwd_sel), .stall(d_stall), .hazard_count(d_hazard_count)
  );

  typedef struct {
    logic             rst, iv, iw;
    logic [RB-1:0]    ird;
    logic [1:0]       ilat;
    logic [NR*RB-1:0] addr;
    logic [NR-1:0]    used;
    logic [DP-1:0]    flush;
    logic [NR*SW-1:0] esel;
    logic             estall;
    logic [15:0]      ehc;
  } vec_t;

  typedef struct {
    int t;
    int rd;
    int clat;
  } mw_t;

  vec_t vecs[$];
  mw_t  inflight[$];
  int   cyc = 0;
  int   m_hc = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [NR*RB-1:0] pa(int a0, int a1, int a2, int a3);
    return {RB'(a3), RB'(a2), RB'(a1), RB'(a0)};
  endfunction

  function automatic logic [NR*SW-1:0] ps(int s0, int s1, int s2, int s3);
    return {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
  endfunction

  function automatic vec_t mk(int r, int iv, int iw, int ird, int ilat, logic [NR*RB-1:0] addr,
                              int used, int flush, logic [NR*SW-1:0] esel, int estall, int ehc);
    vec_t v;
    v.rst = 1'(r); v.iv = 1'(iv); v.iw = 1'(iw); v.ird = RB'(ird); v.ilat = 2'(ilat);
    v.addr = addr; v.used = NR'(used); v.flush = DP'(flush);
    v.esel = esel; v.estall = 1'(estall); v.ehc = 16'(ehc);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; issue_valid = v.iv; issue_wr_en = v.iw; issue_rd = v.ird;
    issue_lat = v.ilat; rd_addr = v.addr; rd_used = v.used; flush_mask = v.flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each tracked write remembers the cycle it entered stage 1
  // (age = cycles since) and when it becomes forwardable (age-1 >= clat).
  function automatic void model_outputs(input logic [NR*RB-1:0] addr, input logic [NR-1:0] used,
                                        output logic [NR*SW-1:0] esel, output logic estall);
    esel = '0;
    estall = 1'b0;
    for (int i = 0; i < NR; i++) begin
      int a, best, bclat;
      a = int'(addr[i*RB +: RB]);
      best = 0;
      bclat = 0;
      if (a != 0) begin
        foreach (inflight[j]) begin
          int age;
          age = cyc - inflight[j].t;
          if (age >= 1 && age <= DP && inflight[j].rd == a && (best == 0 || age < best)) begin
            best = age;
            bclat = inflight[j].clat;
          end
        end
      end
      if (best != 0) begin
        if (best - 1 >= bclat) esel[i*SW +: SW] = SW'(best);
        else if (used[i]) estall = 1'b1;
      end
    end
  endfunction

  task automatic model_edge(input logic r, input logic estall);
    if (r) begin
      inflight.delete();
      m_hc = 0;
    end else begin
      if (estall && m_hc < 65535) m_hc++;
      for (int j = inflight.size() - 1; j >= 0; j--) begin
        int age;
        age = cyc - inflight[j].t;
        if (age >= DP || (age >= 1 && flush_mask[age-1])) inflight.delete(j);
      end
      if (issue_valid && issue_wr_en && !estall && issue_rd != 0 && !flush_mask[0])
        inflight.push_back('{t: cyc, rd: int'(issue_rd), clat: (issue_lat > 2) ? 2 : int'(issue_lat)});
    end
    cyc++;
  endtask

  initial begin
    logic [NR*SW-1:0] esel;
    logic             estall;

    // reset, ALU forwarding, load-use, youngest-wins, flush, clamp, reset mid-stall
    vecs.push_back(mk(1,0,0,0,0, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 0));
    vecs.push_back(mk(1,0,0,0,0, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 0));
    vecs.push_back(mk(0,0,0,0,0, pa(5,5,5,5), 15, 0, ps(0,0,0,0), 0, 0));
    vecs.push_back(mk(0,1,1,3,0, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 0));
    vecs.push_back(mk(0,1,0,0,0, pa(3,0,0,0), 1, 0, ps(1,0,0,0), 0, 0));
    vecs.push_back(mk(0,0,0,0,0, pa(3,0,0,0), 1, 0, ps(2,0,0,0), 0, 0));
    vecs.push_back(mk(0,0,0,0,0, pa(3,0,0,0), 1, 0, ps(3,0,0,0), 0, 0));
    vecs.push_back(mk(0,1,1,4,1, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 0));
    vecs.push_back(mk(0,0,0,0,0, pa(0,4,0,0), 2, 0, ps(0,0,0,0), 1, 0));
    vecs.push_back(mk(0,0,0,0,0, pa(0,4,0,0), 2, 0, ps(0,2,0,0), 0, 1));
    vecs.push_back(mk(0,1,1,4,1, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 1));
    vecs.push_back(mk(0,0,0,0,0, pa(0,4,0,0), 0, 0, ps(0,0,0,0), 0, 1));
    vecs.push_back(mk(0,0,0,0,0, pa(0,4,0,0), 0, 0, ps(0,2,0,0), 0, 1));
    vecs.push_back(mk(0,1,1,7,0, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 1));
    vecs.push_back(mk(0,1,1,7,0, pa(0,0,7,0), 4, 0, ps(0,0,1,0), 0, 1));
    vecs.push_back(mk(0,1,1,0,0, pa(0,0,7,0), 15, 0, ps(0,0,1,0), 0, 1));
    vecs.push_back(mk(0,0,0,0,0, pa(0,0,7,0), 15, 0, ps(0,0,2,0), 0, 1));
    vecs.push_back(mk(0,1,1,9,0, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 1));
    vecs.push_back(mk(0,0,0,0,0, pa(0,0,0,0), 0, 1, ps(0,0,0,0), 0, 1));
    vecs.push_back(mk(0,0,0,0,0, pa(9,0,0,0), 1, 0, ps(0,0,0,0), 0, 1));
    vecs.push_back(mk(0,1,1,9,3, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 1));
    vecs.push_back(mk(0,0,0,0,0, pa(9,0,0,0), 1, 0, ps(0,0,0,0), 1, 1));
    vecs.push_back(mk(0,0,0,0,0, pa(9,0,0,0), 1, 0, ps(0,0,0,0), 1, 2));
    vecs.push_back(mk(0,0,0,0,0, pa(9,0,0,0), 1, 0, ps(3,0,0,0), 0, 3));
    vecs.push_back(mk(0,1,1,9,1, pa(0,0,0,0), 0, 0, ps(0,0,0,0), 0, 3));
    vecs.push_back(mk(1,0,0,0,0, pa(9,0,0,0), 1, 0, ps(0,0,0,0), 1, 3));
    vecs.push_back(mk(0,0,0,0,0, pa(9,0,0,0), 1, 0, ps(0,0,0,0), 0, 0));

    @(posedge clk); #1;
    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_sel", n), 32'(fwd_sel), 32'(vecs[n].esel));
      checkOutput($sformatf("vec%0d_stall", n), 32'(stall), 32'(vecs[n].estall));
      checkOutput($sformatf("vec%0d_hc", n), 32'(hazard_count), 32'(vecs[n].ehc));
      @(posedge clk); #1;
    end

    rst = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 1'b0);
    #1;
    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_wr_en = ($urandom_range(0, 9) < 8);
      issue_rd    = RB'($urandom_range(0, 3));
      issue_lat   = 2'($urandom_range(0, 3));
      for (int i = 0; i < NR; i++) rd_addr[i*RB +: RB] = RB'($urandom_range(0, 3));
      rd_used     = NR'($urandom);
      flush_mask  = ($urandom_range(0, 7) == 0) ? DP'($urandom) : '0;
      model_outputs(rd_addr, rd_used, esel, estall);
      @(negedge clk);
      checkOutput("rand_sel", 32'(fwd_sel), 32'(esel));
      checkOutput("rand_stall", 32'(stall), 32'(estall));
      checkOutput("rand_hc", 32'(hazard_count), 32'(m_hc));
      @(posedge clk);
      model_edge(rst, estall);
      #1;
    end
    rst = 1'b0; issue_valid = 1'b0; rd_used = '0; flush_mask = '0;

    // Deep instance: one write of latency 31 stalls its reader 31 of every 32 cycles.
    d_issue_valid = 1'b1; d_issue_wr_en = 1'b1; d_issue_rd = RB'(5);
    d_issue_lat = DLB'(31); d_rd_addr = pa(5,0,0,0); d_rd_used = NR'(1);
    d_rst = 1'b0;
    for (int n = 0; n <= 68005; n++) begin
      @(negedge clk);
      if (n == 320) begin
        checkOutput("deep_hc_320", 32'(d_hazard_count), 32'd310);
        checkOutput("deep_stall_320", 32'(d_stall), 32'd0);
        checkOutput("deep_sel_320", 32'(d_fwd_sel[DSW-1:0]), 32'd32);
      end
      if (n == 321) checkOutput("deep_stall_321", 32'(d_stall), 32'd1);
    end
    checkOutput("deep_hc_sat", 32'(d_hazard_count), 32'hFFFF);
    checkOutput("deep_stall_presat", 32'(d_stall), 32'd1);
    @(negedge clk);
    checkOutput("deep_hc_hold", 32'(d_hazard_count), 32'hFFFF);
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    checkOutput("deep_rst_stall", 32'(d_stall), 32'd0);
    checkOutput("deep_rst_hc", 32'(d_hazard_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
